// File: rtl/sdram_arb_pkg.sv
// ============================================================================
// sdram_arb_pkg : shared types and default widths for the SDRAM R/W arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package sdram_arb_pkg;

  localparam int DEF_ADDR_W   = 24;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_LEN_W    = 10;
  localparam int DEF_MAX_OUTS = 8;
  // Outstanding counter width; MAX_OUTS is limited to 15.
  localparam int OUTS_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_t;

endpackage

`default_nettype wire

// File: rtl/sdram_rr_arbiter.sv
// ============================================================================
// sdram_rr_arbiter : 2-way round-robin grant with last-grant memory
// Rev 1.0
// ============================================================================
`default_nettype none

module sdram_rr_arbiter
  import sdram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic wr_req,
  input  logic rd_req,
  output logic gnt_valid,
  output logic gnt_rd
);

  grant_t last_gnt;
  grant_t pick;

  always_comb begin
    pick = GNT_WR;
    if (wr_req && rd_req) begin
      pick = (last_gnt == GNT_RD) ? GNT_WR : GNT_RD;
    end else if (rd_req) begin
      pick = GNT_RD;
    end
  end

  assign gnt_valid = sample && (wr_req || rd_req);
  assign gnt_rd    = (pick == GNT_RD);

  // Last grant starts as READ so the writer wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= GNT_RD;
    end else if (gnt_valid) begin
      last_gnt <= pick;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sdram_rw_arbiter.sv
// ============================================================================
// sdram_rw_arbiter : shares one SDRAM Avalon-MM port between a burst writer
//                    and a pipelined burst reader
// Rev 1.0
// ============================================================================
`default_nettype none

module sdram_rw_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int MAX_OUTS = DEF_MAX_OUTS
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_ack,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_data_rd,
  output logic              wr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_vld,
  output logic              rd_done,
  output logic [ADDR_W-1:0] avs_port_address,
  output logic [1:0]        avs_port_byteenable_n,
  output logic              avs_port_chipselect,
  output logic [DATA_W-1:0] avs_port_writedata,
  output logic              avs_port_read_n,
  output logic              avs_port_write_n,
  input  logic [DATA_W-1:0] avs_port_readdata,
  input  logic              avs_port_readdatavalid,
  input  logic              avs_port_waitrequest
);

  localparam logic [OUTS_W-1:0] MAX_OUTS_V = OUTS_W'(MAX_OUTS);
  localparam logic [LEN_W-1:0]  LEN_ONE    = LEN_W'(1);

  state_t              state;
  logic [ADDR_W-1:0]   cur_addr;
  logic [LEN_W-1:0]    remain;
  logic [OUTS_W-1:0]   outstanding;

  logic                gnt_valid;
  logic                gnt_rd;
  logic                wr_active;
  logic                rd_issue;
  logic                wr_accept;
  logic                rd_accept;
  logic                rdv_take;

  sdram_rr_arbiter u_rr (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .sample    ((state == ST_IDLE) && (outstanding == '0)),
    .wr_req    (wr_req),
    .rd_req    (rd_req),
    .gnt_valid (gnt_valid),
    .gnt_rd    (gnt_rd)
  );

  // Bus strobes depend only on registered state, so they stay put under waitrequest.
  always_comb begin
    wr_active = (state == ST_WRITE) && (remain != '0);
    rd_issue  = (state == ST_READ) && (remain != '0) && (outstanding < MAX_OUTS_V);
    wr_accept = wr_active && !avs_port_waitrequest;
    rd_accept = rd_issue && !avs_port_waitrequest;
    rdv_take  = avs_port_readdatavalid && (outstanding != '0);
  end

  assign avs_port_address      = cur_addr;
  assign avs_port_byteenable_n = 2'b00;
  assign avs_port_chipselect   = wr_active || rd_issue;
  assign avs_port_write_n      = !wr_active;
  assign avs_port_read_n       = !rd_issue;
  assign avs_port_writedata    = wr_data;
  assign wr_data_rd            = wr_accept;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state    <= ST_IDLE;
      cur_addr <= '0;
      remain   <= '0;
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
    end else begin
      wr_ack  <= 1'b0;
      rd_ack  <= 1'b0;
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            if (gnt_rd) begin
              state    <= ST_READ;
              cur_addr <= rd_addr;
              remain   <= rd_len;
              rd_ack   <= 1'b1;
            end else begin
              state    <= ST_WRITE;
              cur_addr <= wr_addr;
              remain   <= wr_len;
              wr_ack   <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (remain == '0) begin
            wr_done <= 1'b1;
            state   <= ST_IDLE;
          end else if (wr_accept) begin
            cur_addr <= cur_addr + 1'b1;
            remain   <= remain - 1'b1;
            if (remain == LEN_ONE) begin
              wr_done <= 1'b1;
              state   <= ST_IDLE;
            end
          end
        end
        ST_READ: begin
          // Zero-length read finishes at once; otherwise the last command moves us to DRAIN.
          if (remain == '0) begin
            rd_done <= 1'b1;
            state   <= ST_IDLE;
          end else if (rd_accept) begin
            cur_addr <= cur_addr + 1'b1;
            remain   <= remain - 1'b1;
            if (remain == LEN_ONE) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (rdv_take && (outstanding == OUTS_W'(1))) begin
            rd_done <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      outstanding <= '0;
    end else begin
      case ({rd_accept, rdv_take})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Returned data with nothing outstanding is stale (e.g. after reset) and is dropped.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rd_data     <= '0;
      rd_data_vld <= 1'b0;
    end else begin
      rd_data_vld <= rdv_take;
      if (rdv_take) begin
        rd_data <= avs_port_readdata;
      end
    end
  end

endmodule

`default_nettype wire
